e203_rst_seq: RTL



---
 rtl/e203_rst_pkg.sv | 21 ++
 rtl/e203_sync_filt.sv | 55 +++++
 rtl/e203_rst_seq.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/e203_rst_pkg.sv
// Shared types and constants for the E203 reset sequencer.
package e203_rst_pkg;

    typedef enum logic [1:0] {
        RESET   = 2'd0,
        WAIT_OK = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } rst_state_e;

    // Bit positions inside rst_cause
    localparam int unsigned CAUSE_POR  = 0;
    localparam int unsigned CAUSE_EXT  = 1;
    localparam int unsigned CAUSE_LOCK = 2;
    localparam int unsigned CAUSE_SW   = 3;
    localparam int unsigned CAUSE_W    = 4;

    // Value loaded on power-on reset: only the POR cause flagged
    localparam logic [CAUSE_W-1:0] CAUSE_RST_VAL = CAUSE_W'(1) << CAUSE_POR;

endpackage

// File: rtl/e203_sync_filt.sv
// Two-flop synchronizer followed by an optional level filter. The filter output only
// follows the synchronized input after FILT_LEN consecutive cycles at the new level;
// FILT_LEN = 0 bypasses the filter and exposes the synchronizer output directly.
module e203_sync_filt #(
    parameter int unsigned FILT_LEN = 16,
    parameter bit          RST_VAL  = 1'b0,
    parameter int unsigned CNT_W    = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic s1_q;
    logic s2_q;

    // Metastability guard for the asynchronous input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= din;
            s2_q <= s1_q;
        end
    end

    if (FILT_LEN == 0) begin : g_bypass
        assign dout = s2_q;
    end else begin : g_filt
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

        logic             out_q;
        logic [CNT_W-1:0] cnt_q;

        // Count cycles at a level different from the output; any return restarts it
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_q <= RST_VAL;
                cnt_q <= '0;
            end else if (s2_q == out_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                out_q <= s2_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign dout = out_q;
    end

endmodule

// File: rtl/e203_rst_seq.sv
// Reset sequencer: filters the board reset, supervises PLL lock, accepts a soft reset
// request, releases N_DOM reset domains one after another and records why the last
// reset happened in a sticky cause register.
module e203_rst_seq
    import e203_rst_pkg::*;
#(
    parameter int unsigned N_DOM    = 4,
    parameter int unsigned EXT_FILT = 16,
    parameter int unsigned HOLD_CYC = 8,
    parameter int unsigned CNT_W    = $clog2((EXT_FILT > HOLD_CYC) ? EXT_FILT : HOLD_CYC) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ext_rst_n,
    input  logic               pll_locked,
    input  logic               sw_rst_req,
    input  logic               cause_clr,
    output logic [N_DOM-1:0]   dom_rst_n,
    output logic               seq_done,
    output logic [CAUSE_W-1:0] rst_cause
);

    localparam int unsigned      IDX_W     = (N_DOM > 1) ? $clog2(N_DOM) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DOM - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);

    logic ext_ok;
    logic lock_ok;
    logic fault;
    logic fault_hit;

    rst_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N_DOM-1:0]   dom_q, dom_d;
    logic               done_q, done_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;

    e203_sync_filt #(
        .FILT_LEN (EXT_FILT),
        .RST_VAL  (1'b0),
        .CNT_W    (CNT_W)
    ) u_ext_filt (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ext_rst_n),
        .dout  (ext_ok)
    );

    e203_sync_filt #(
        .FILT_LEN (0),
        .RST_VAL  (1'b0),
        .CNT_W    (CNT_W)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (pll_locked),
        .dout  (lock_ok)
    );

    assign fault     = !ext_ok | !lock_ok | sw_rst_req;
    // Inside RESET a fault only restarts the dwell; it is not a new reset event
    assign fault_hit = fault && (state_q != RESET);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RESET: begin
                if (!fault && cnt_q == HOLD_LAST) state_d = WAIT_OK;
            end
            WAIT_OK: begin
                if (fault)                  state_d = RESET;
                else if (ext_ok && lock_ok) state_d = RELEASE;
            end
            RELEASE: begin
                if (fault)                                         state_d = RESET;
                else if (cnt_q == HOLD_LAST && idx_q == IDX_LAST) state_d = RUN;
            end
            RUN: begin
                if (fault) state_d = RESET;
            end
            default: state_d = RESET;
        endcase
    end

    // Datapath next values: dwell/spacing counter, domain index, outputs, cause bits
    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        dom_d   = dom_q;
        done_d  = done_q;
        cause_d = cause_q;

        unique case (state_q)
            RESET: begin
                dom_d  = '0;
                idx_d  = '0;
                done_d = 1'b0;
                cnt_d  = (fault || cnt_q == HOLD_LAST) ? '0 : cnt_q + 1'b1;
            end
            WAIT_OK: begin
                cnt_d = '0;
            end
            RELEASE: begin
                if (cnt_q == HOLD_LAST) begin
                    for (int i = 0; i < N_DOM; i++) begin
                        if (idx_q == IDX_W'(i)) dom_d[i] = 1'b1;
                    end
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d  = '0;
                        done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                cnt_d = '0;
            end
            default: begin
                cnt_d = '0;
            end
        endcase

        if (fault_hit) begin
            dom_d  = '0;
            done_d = 1'b0;
            cnt_d  = '0;
            idx_d  = '0;
        end

        // Clear first so a same-cycle set event survives
        if (cause_clr) cause_d = '0;
        if (fault_hit) begin
            if (!ext_ok)    cause_d[CAUSE_EXT]  = 1'b1;
            if (!lock_ok)   cause_d[CAUSE_LOCK] = 1'b1;
            if (sw_rst_req) cause_d[CAUSE_SW]   = 1'b1;
        end
    end

    // Datapath registers; every output comes straight from a flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            dom_q   <= '0;
            done_q  <= 1'b0;
            cause_q <= CAUSE_RST_VAL;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dom_q   <= dom_d;
            done_q  <= done_d;
            cause_q <= cause_d;
        end
    end

    assign dom_rst_n = dom_q;
    assign seq_done  = done_q;
    assign rst_cause = cause_q;

endmodule
